// File: rtl/adc_frame_align_if.sv
// ============================================================================
//  Module   : adc_frame_align_if
//  Purpose  : Control/status bundle between a frame aligner and its user.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_frame_align_if #(
   parameter int WIDTH = 6
);
   logic             start;
   logic [WIDTH-1:0] frame;
   logic             serdes_rst;
   logic             bs;
   logic             busy;
   logic             locked;
   logic             fail;
   logic [3:0]       slip_cnt;

   modport master (
      output start, frame,
      input  serdes_rst, bs, busy, locked, fail, slip_cnt
   );

   modport slave (
      input  start, frame,
      output serdes_rst, bs, busy, locked, fail, slip_cnt
   );
endinterface

`default_nettype wire

// File: rtl/adc_frame_align.sv
// ============================================================================
//  Module   : adc_frame_align
//  Purpose  : ISERDES2 word-alignment sequencer: reset, bitslip until the frame
//             word matches PATTERN, verify, lock. Optional lock monitor is
//             enabled by defining ADC_ALIGN_MON_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_frame_align #(
   parameter int               WIDTH    = 6,
   parameter logic [WIDTH-1:0] PATTERN  = 6'b111000,
   parameter int               RST_CYC  = 4,
   parameter int               SETTLE   = 4,
   parameter int               VERIFY   = 16,
   parameter int               MAX_SLIP = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   adc_frame_align_if.slave   bus
);

   localparam int TMR_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RESET  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_SLIP   = 3'd4,
      ST_VERIFY = 3'd5,
      ST_LOCK   = 3'd6,
      ST_FAILED = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [7:0]       match_q, match_d;
   logic             serdes_rst_q, serdes_rst_d;
   logic             bs_q, bs_d;
   logic             busy_q, busy_d;
   logic             locked_q, locked_d;
   logic             fail_q, fail_d;
   logic [3:0]       slip_cnt_q, slip_cnt_d;
   logic             w_match;
   logic             w_enter_reset;

`ifdef ADC_ALIGN_MON_EN
   localparam int MISS_LIMIT = 3;
   logic [1:0] miss_q, miss_d;
`endif

   assign w_match = (bus.frame == PATTERN);

   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      match_d       = match_q;
      serdes_rst_d  = serdes_rst_q;
      bs_d          = 1'b0;
      busy_d        = busy_q;
      locked_d      = locked_q;
      fail_d        = fail_q;
      slip_cnt_d    = slip_cnt_q;
      w_enter_reset = 1'b0;
`ifdef ADC_ALIGN_MON_EN
      miss_d        = miss_q;
`endif

      case (state_q)
         ST_IDLE, ST_FAILED: begin
            if (bus.start) w_enter_reset = 1'b1;
         end
         ST_RESET: begin
            if (tmr_q == TMR_W'(RST_CYC - 1)) begin
               state_d      = ST_SETTLE;
               tmr_d        = '0;
               serdes_rst_d = 1'b0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_SETTLE: begin
            if (tmr_q == TMR_W'(SETTLE - 1)) state_d = ST_CHECK;
            else                             tmr_d   = tmr_q + 1'b1;
         end
         ST_CHECK: begin
            if (w_match) begin
               if (VERIFY == 1) begin
                  state_d  = ST_LOCK;
                  locked_d = 1'b1;
                  busy_d   = 1'b0;
               end else begin
                  state_d = ST_VERIFY;
                  match_d = 8'd1;
               end
            end else if (slip_cnt_q == 4'(MAX_SLIP)) begin
               state_d = ST_FAILED;
               fail_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d    = ST_SLIP;
               bs_d       = 1'b1;
               slip_cnt_d = slip_cnt_q + 1'b1;
            end
         end
         ST_SLIP: begin
            state_d = ST_SETTLE;
            tmr_d   = '0;
         end
         ST_VERIFY: begin
            if (w_match) begin
               if (match_q == 8'(VERIFY - 1)) begin
                  state_d  = ST_LOCK;
                  match_d  = '0;
                  locked_d = 1'b1;
                  busy_d   = 1'b0;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end else begin
               // Recheck the same word after settling; a glitch must not cost a slip.
               state_d = ST_SETTLE;
               tmr_d   = '0;
               match_d = '0;
            end
         end
         ST_LOCK: begin
            if (bus.start) begin
               w_enter_reset = 1'b1;
`ifdef ADC_ALIGN_MON_EN
            end else if (!w_match) begin
               if (miss_q == 2'(MISS_LIMIT - 1)) w_enter_reset = 1'b1;
               else                              miss_d        = miss_q + 1'b1;
            end else begin
               miss_d = '0;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (w_enter_reset) begin
         state_d      = ST_RESET;
         tmr_d        = '0;
         match_d      = '0;
         serdes_rst_d = 1'b1;
         busy_d       = 1'b1;
         locked_d     = 1'b0;
         fail_d       = 1'b0;
         slip_cnt_d   = '0;
`ifdef ADC_ALIGN_MON_EN
         miss_d       = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tmr_q        <= '0;
         match_q      <= '0;
         serdes_rst_q <= 1'b0;
         bs_q         <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
         slip_cnt_q   <= '0;
`ifdef ADC_ALIGN_MON_EN
         miss_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         match_q      <= match_d;
         serdes_rst_q <= serdes_rst_d;
         bs_q         <= bs_d;
         busy_q       <= busy_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
         slip_cnt_q   <= slip_cnt_d;
`ifdef ADC_ALIGN_MON_EN
         miss_q       <= miss_d;
`endif
      end
   end

   assign bus.serdes_rst = serdes_rst_q;
   assign bus.bs         = bs_q;
   assign bus.busy       = busy_q;
   assign bus.locked     = locked_q;
   assign bus.fail       = fail_q;
   assign bus.slip_cnt   = slip_cnt_q;

endmodule

`default_nettype wire
